util_timestamp_wr_sync: RTL



---
 rtl/util_timestamp_pkg.sv | 13 +
 rtl/util_sample_counter.sv | 23 ++
 rtl/util_timestamp_wr_sync.sv | 105 ++++++++++
 3 files changed

// File: rtl/util_timestamp_pkg.sv
// Shared types and default widths for the timestamp-driven write-sync generator.
package util_timestamp_pkg;

    localparam int unsigned TS_WIDTH_DEF    = 64;
    localparam int unsigned EVERY_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } ts_state_t;

endpackage

// File: rtl/util_sample_counter.sv
// Free-running sample index; advances once per consumed sample and wraps.
module util_sample_counter #(
    parameter int unsigned TS_WIDTH = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    output logic [TS_WIDTH-1:0] count
);

    logic [TS_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + TS_WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/util_timestamp_wr_sync.sv
// Opens a write window of timestamp_every samples starting after the sample whose
// index equals an accepted target; targets already passed are dropped with a late pulse.
module util_timestamp_wr_sync
    import util_timestamp_pkg::*;
#(
    parameter int unsigned TS_WIDTH    = TS_WIDTH_DEF,
    parameter int unsigned EVERY_WIDTH = EVERY_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [EVERY_WIDTH-1:0] timestamp_every,
    input  logic                   sample_valid,
    input  logic [TS_WIDTH-1:0]    ts_data,
    input  logic                   ts_valid,
    output logic                   ts_ready,
    output logic [TS_WIDTH-1:0]    sample_count,
    output logic                   timestamp_wr_sync,
    output logic                   late
);

    ts_state_t              r_state;
    ts_state_t              w_state_nxt;
    logic [TS_WIDTH-1:0]    r_target;
    logic [EVERY_WIDTH-1:0] r_len;
    logic [EVERY_WIDTH-1:0] r_remaining;
    logic                   r_wr_sync;
    logic                   r_late;
    logic                   w_late_nxt;
    logic [TS_WIDTH-1:0]    w_count;
    logic                   w_accept;
    logic                   w_match;
    logic                   w_past;
    logic                   w_last;

    util_sample_counter #(
        .TS_WIDTH(TS_WIDTH)
    ) u_counter (
        .clk    (clk),
        .resetn (resetn),
        .en     (sample_valid),
        .count  (w_count)
    );

    assign w_accept = ts_valid && (r_state == ST_IDLE);
    assign w_match  = sample_valid && (w_count == r_target);
    assign w_past   = w_count > r_target;
    assign w_last   = sample_valid && (r_remaining == EVERY_WIDTH'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_late_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A zero window length consumes the target without arming.
                if (w_accept && (timestamp_every != '0)) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_match) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_past) begin
                    w_state_nxt = ST_IDLE;
                    w_late_nxt  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_wr_sync   <= 1'b0;
            r_late      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_late    <= w_late_nxt;
            r_wr_sync <= (w_state_nxt == ST_ACTIVE);
            if (w_accept) begin
                r_target <= ts_data;
                r_len    <= timestamp_every;
            end
            if ((r_state == ST_ARMED) && w_match) begin
                r_remaining <= r_len;
            end else if ((r_state == ST_ACTIVE) && sample_valid) begin
                r_remaining <= r_remaining - EVERY_WIDTH'(1);
            end
        end
    end

    assign ts_ready          = (r_state == ST_IDLE);
    assign sample_count      = w_count;
    assign timestamp_wr_sync = r_wr_sync;
    assign late              = r_late;

endmodule
